// File: rtl/dsc_scan_if.sv
// +----------------------------------------------------------------------+
// | Module  : dsc_scan_if                                                |
// | Purpose : Raster, converter-return, SRAM and display-path bundle.    |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

interface dsc_scan_if;
  logic        frame_start;
  logic [9:0]  Row;
  logic [9:0]  Column;
  logic [18:0] dsc_addr;
  logic        dsc_in_region;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic        wr_gnt;
  logic [18:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        pix_valid;
  logic        pix_in_region;
  logic        busy;
  logic        frame_done;

  modport slave (
    input  frame_start, dsc_addr, dsc_in_region, wr_req, wr_addr,
    output Row, Column, wr_gnt, sram_addr, sram_we_n, sram_oe_n,
           pix_valid, pix_in_region, busy, frame_done
  );

  modport master (
    output frame_start, dsc_addr, dsc_in_region, wr_req, wr_addr,
    input  Row, Column, wr_gnt, sram_addr, sram_we_n, sram_oe_n,
           pix_valid, pix_in_region, busy, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/dsc_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | Module  : dsc_scan_ctrl                                              |
// | Purpose : Raster sequencer and echo-SRAM arbiter for scan converter. |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module dsc_scan_ctrl #(
  parameter int H_ACTIVE = 334,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int PIPE_LAT = 20,
  parameter int RD_LAT   = 2
) (
  input  logic        LCLK,
  input  logic        RSTn,
  dsc_scan_if.slave   bus
);

  localparam int              c_BLANK_W   = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam logic [c_BLANK_W-1:0] c_BLANK_LAST = c_BLANK_W'(H_BLANK - 1);
  localparam logic [9:0]      c_COL_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]      c_ROW_LAST  = 10'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_BLANK  = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [9:0]             r_row;
  logic [9:0]             r_col;
  logic                   r_cv;
  logic [c_BLANK_W-1:0]   r_blank_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_bubble_pend;
  logic [PIPE_LAT-1:0]    r_vpipe;
  logic [RD_LAT-1:0]      r_rdv;
  logic [RD_LAT-1:0]      r_rdr;

  logic w_rd_slot;
  logic w_grant;
  logic w_last;
  logic w_bubble;
  logic w_inflight;

  // A converter read slot always owns the SRAM; writes only fill empty slots.
  assign w_rd_slot  = r_vpipe[PIPE_LAT-1];
  assign w_grant    = RSTn && !w_rd_slot && bus.wr_req;
  assign w_last     = (r_state == S_ACTIVE) && r_cv && (r_col == c_COL_LAST);
  assign w_bubble   = (r_state == S_ACTIVE) && !w_last && bus.wr_req &&
                      !w_grant && !r_bubble_pend;
  assign w_inflight = (|r_vpipe) | (|r_rdv);

  assign bus.Row           = r_row;
  assign bus.Column        = r_col;
  assign bus.wr_gnt        = w_grant;
  assign bus.sram_addr     = w_rd_slot ? bus.dsc_addr : (w_grant ? bus.wr_addr : '0);
  assign bus.sram_oe_n     = !w_rd_slot;
  assign bus.sram_we_n     = !w_grant;
  assign bus.pix_valid     = r_rdv[RD_LAT-1];
  assign bus.pix_in_region = r_rdr[RD_LAT-1];
  assign bus.busy          = r_busy;
  assign bus.frame_done    = r_done;

  always_ff @(posedge LCLK) begin
    if (!RSTn) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_cv          <= 1'b0;
      r_blank_cnt   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_bubble_pend <= 1'b0;
      r_vpipe       <= '0;
      r_rdv         <= '0;
      r_rdr         <= '0;
    end else begin
      r_vpipe[0] <= r_cv;
      for (int i = 1; i < PIPE_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
      r_rdv[0] <= w_rd_slot;
      r_rdr[0] <= w_rd_slot & bus.dsc_in_region;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rdv[i] <= r_rdv[i-1];
        r_rdr[i] <= r_rdr[i-1];
      end

      r_done <= 1'b0;
      if (w_grant)       r_bubble_pend <= 1'b0;
      else if (w_bubble) r_bubble_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_cv <= 1'b0;
          if (bus.frame_start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_cv    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          // Any coordinate shown in ACTIVE has already been issued, so a
          // non-bubble cycle always advances to the next column.
          if (w_last) begin
            r_cv        <= 1'b0;
            r_blank_cnt <= '0;
            r_state     <= S_BLANK;
          end else if (w_bubble) begin
            r_cv <= 1'b0;
          end else begin
            r_cv  <= 1'b1;
            r_col <= r_col + 10'd1;
          end
        end
        S_BLANK: begin
          r_cv <= 1'b0;
          if (r_blank_cnt == c_BLANK_LAST) begin
            if (r_row == c_ROW_LAST) begin
              r_state <= S_DRAIN;
            end else begin
              r_row   <= r_row + 10'd1;
              r_col   <= '0;
              r_cv    <= 1'b1;
              r_state <= S_ACTIVE;
            end
          end else begin
            r_blank_cnt <= r_blank_cnt + c_BLANK_W'(1);
          end
        end
        S_DRAIN: begin
          r_cv <= 1'b0;
          if (!w_inflight) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_cv    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cv    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsc_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | Module  : tb_dsc_scan_ctrl                                           |
// | Purpose : Directed bench for dsc_scan_ctrl on a reduced raster.      |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dsc_scan_ctrl;
  localparam int H  = 24;
  localparam int V  = 5;
  localparam int HB = 24;
  localparam int PL = 20;
  localparam int RL = 2;
  // frame_start cycle -> first issue +1; last issue at +1+(V-1)*(H+HB)+H-1;
  // blanking of the last row ends HB later, one DRAIN cycle, then DONE.
  localparam int DONE_OFF = 1 + (V-1)*(H+HB) + (H-1) + HB + 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  dsc_scan_if bus();

  dsc_scan_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .PIPE_LAT(PL), .RD_LAT(RL))
    dut (.LCLK(clk), .RSTn(rstn), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0, checks = 0, failures = 0, pix_cnt = 0, done_cnt = 0;
  logic fs_d = 1'b0, req_d = 1'b0, rst_d = 1'b1;
  logic [18:0] waddr_d = '0;
  logic [9:0] row_h [64];
  logic [9:0] col_h [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: record the raster, model the converter, drive inputs, sample.
  task automatic tick();
    int p, q;
    logic reg_exp;
    @(negedge clk);
    cyc++;
    row_h[cyc % 64] = bus.Row;
    col_h[cyc % 64] = bus.Column;
    p = (cyc + 64 - PL) % 64;
    q = (cyc + 64 - PL - RL) % 64;
    bus.dsc_addr      = 19'(row_h[p] * H + col_h[p]);
    bus.dsc_in_region = ~col_h[p][0];
    bus.frame_start   = fs_d;
    bus.wr_req        = req_d;
    bus.wr_addr       = waddr_d;
    rstn              = ~rst_d;
    #1;
    if (bus.pix_valid) begin
      pix_cnt++;
      reg_exp = ~col_h[q][0];
      chk("pix_in_region", bus.pix_in_region, reg_exp);
    end
    if (bus.frame_done) done_cnt++;
    if (!bus.sram_oe_n) begin
      chk("rd_addr", bus.sram_addr, row_h[p] * H + col_h[p]);
      chk("rd_no_gnt", bus.wr_gnt, 0);
    end
    if (bus.wr_gnt) begin
      chk("wr_we_n", bus.sram_we_n, 0);
      chk("wr_oe_n", bus.sram_oe_n, 1);
      chk("wr_addr", bus.sram_addr, waddr_d);
    end
  endtask

  task automatic chk_reset();
    chk("rst_row", bus.Row, 0);
    chk("rst_col", bus.Column, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pix", bus.pix_valid, 0);
    chk("rst_region", bus.pix_in_region, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_gnt", bus.wr_gnt, 0);
    chk("rst_we_n", bus.sram_we_n, 1);
    chk("rst_oe_n", bus.sram_oe_n, 1);
    chk("rst_addr", bus.sram_addr, 0);
  endtask

  // mode 0: plain frame; 2: write late in row 2; 3: write in blanking + extra frame_start
  task automatic run_frame(input int mode, input int exp_done);
    int fc, first, done_c, q, m, g;
    pix_cnt = 0; done_cnt = 0; first = -1; done_c = -1; q = -1; m = -1; g = -1;
    fs_d = 1'b1; tick(); fc = cyc; fs_d = 1'b0;
    chk("busy_before_accept", bus.busy, 0);
    for (int i = 0; i < 400 && done_c < 0; i++) begin
      tick();
      if (cyc == fc + 1) chk("busy_on", bus.busy, 1);
      if (bus.pix_valid && first < 0) first = cyc;
      if (bus.frame_done) begin
        done_c = cyc;
        chk("busy_at_done", bus.busy, 0);
      end
      if (mode == 2) begin
        if (q < 0 && bus.Row == 10'd2 && bus.Column == 10'd21) begin
          req_d = 1'b1; waddr_d = 19'h5A5A5; q = cyc + 1;
        end else if (cyc == q) begin
          chk("rd_beats_wr", bus.wr_gnt, 0);
        end else if (cyc == q + 1) begin
          chk("bubble_hold", bus.Column, 22);
        end else if (cyc == q + 2) begin
          chk("bubble_resume", bus.Column, 23);
        end
      end
      if (mode == 3) begin
        if (m < 0 && bus.Row == 10'd1 && bus.Column == 10'd23) m = cyc;
        if (m >= 0 && cyc == m + 21) begin
          req_d = 1'b1; waddr_d = 19'h01234; q = cyc + 1;
        end
        fs_d = (cyc == fc + 49);
      end
      if (req_d && bus.wr_gnt && g < 0) begin
        g = cyc; req_d = 1'b0;
      end
    end
    req_d = 1'b0; fs_d = 1'b0;
    chk("done_seen", done_c >= 0, 1);
    chk("done_time", done_c - fc, exp_done);
    chk("pix_count", pix_cnt, H * V);
    chk("first_pix", first - fc, PL + RL + 1);
    if (mode == 2) chk("wr_wait_bubble", (g >= q) && (g - q <= PL + 1), 1);
    if (mode == 3) chk("wr_wait_blank", (g >= q) && (g - q <= 1), 1);
    tick();
    chk("done_pulse_len", bus.frame_done, 0);
    chk("busy_after", bus.busy, 0);
    chk("done_count", done_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin row_h[i] = '0; col_h[i] = '0; end
    bus.frame_start = 1'b0; bus.wr_req = 1'b0; bus.wr_addr = '0;
    bus.dsc_addr = '0; bus.dsc_in_region = 1'b0;

    rst_d = 1'b1; tick(); tick();
    chk_reset();
    rst_d = 1'b0; tick();

    run_frame(0, DONE_OFF);
    run_frame(2, DONE_OFF + 1);
    run_frame(3, DONE_OFF);

    // Reset in the middle of row 3.
    fs_d = 1'b1; tick(); fs_d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.Row == 10'd3 && bus.Column == 10'd10) break;
    end
    chk("rst_reach_row3", (bus.Row == 10'd3) && (bus.Column == 10'd10), 1);
    rst_d = 1'b1; tick(); rst_d = 1'b0; tick();
    chk_reset();
    pix_cnt = 0; done_cnt = 0;
    repeat (60) tick();
    chk("post_rst_pix", pix_cnt, 0);
    chk("post_rst_done", done_cnt, 0);
    chk("post_rst_busy", bus.busy, 0);

    run_frame(0, DONE_OFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
